// File: rtl/ic_mod_counter.sv
// ic_mod_counter: synchronous modulo-N up/down counter with parallel load,
// 74160-style cep/cet enables, combinational terminal count and a registered
// cascade carry. Instances chain by wiring a lower stage's tc to the next
// stage's cet while sharing cep.

module ic_mod_counter #(
    parameter int WIDTH       = 4,
    parameter int MODULUS     = 10,
    parameter int RESET_VALUE = 0
) (
    input  logic             cp,
    input  logic             mr,
    input  logic             pe_n,
    input  logic [WIDTH-1:0] p,
    input  logic             cep,
    input  logic             cet,
    input  logic             ud,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             tc_r
);

    // Reject illegal parameter combinations at elaboration.
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("ic_mod_counter: WIDTH must be in 1..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("ic_mod_counter: MODULUS must be in 2..2**WIDTH");
    end
    if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset
        $error("ic_mod_counter: RESET_VALUE must be below MODULUS");
    end

    // All arithmetic and compares are done at WIDTH bits; with
    // MODULUS == 2**WIDTH the top state is all ones and the wrap is overflow.
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO  = '0;

    logic [WIDTH-1:0] q_d;
    logic             tc_r_d;
    logic             at_top;
    logic             at_zero;
    logic             out_of_range;

    assign at_top       = (q == MAX_Q);
    assign at_zero      = (q == ZERO);
    assign out_of_range = (q > MAX_Q);

    // Terminal count: gated by cet only, so it ripples through a cascade.
    // An out-of-range q can never equal MAX_Q or zero, so tc stays low there.
    assign tc = cet & (ud ? at_top : at_zero);

    // Next-state selection: load beats count; tc_r only survives a real wrap.
    always_comb begin
        q_d    = q;
        tc_r_d = 1'b0;
        if (!pe_n) begin
            q_d = p;
        end else if (cet && cep) begin
            if (ud) begin
                if (at_top) begin
                    q_d    = ZERO;
                    tc_r_d = 1'b1;
                end else if (out_of_range) begin
                    q_d = ZERO;
                end else begin
                    q_d = q + ONE;
                end
            end else begin
                if (at_zero) begin
                    q_d    = MAX_Q;
                    tc_r_d = 1'b1;
                end else if (out_of_range) begin
                    q_d = MAX_Q;
                end else begin
                    q_d = q - ONE;
                end
            end
        end
    end

    // State register with synchronous master reset taking top priority.
    always_ff @(posedge cp) begin
        if (mr) begin
            q    <= RST_Q;
            tc_r <= 1'b0;
        end else begin
            q    <= q_d;
            tc_r <= tc_r_d;
        end
    end

endmodule

// File: tb/tb_ic_mod_counter.sv
// Directed self-checking bench for ic_mod_counter: default decade counter,
// a two-stage cascade, and two alternate parameterisations.

module tb_ic_mod_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Default instance (WIDTH=4, MODULUS=10, RESET_VALUE=0)
    logic       mr, pe_n, cep, cet, ud;
    logic [3:0] p;
    logic [3:0] q;
    logic       tc, tc_r;

    ic_mod_counter dut (
        .cp(clk), .mr(mr), .pe_n(pe_n), .p(p), .cep(cep), .cet(cet), .ud(ud),
        .q(q), .tc(tc), .tc_r(tc_r)
    );

    // Two-stage decade cascade
    logic       c_mr, c_cep;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, lo_tc_r, hi_tc, hi_tc_r;

    ic_mod_counter u_lo (
        .cp(clk), .mr(c_mr), .pe_n(1'b1), .p(4'd0), .cep(c_cep), .cet(1'b1), .ud(1'b1),
        .q(lo_q), .tc(lo_tc), .tc_r(lo_tc_r)
    );
    ic_mod_counter u_hi (
        .cp(clk), .mr(c_mr), .pe_n(1'b1), .p(4'd0), .cep(c_cep), .cet(lo_tc), .ud(1'b1),
        .q(hi_q), .tc(hi_tc), .tc_r(hi_tc_r)
    );

    // WIDTH=3, MODULUS=8, RESET_VALUE=5
    logic       a_mr, a_en;
    logic [2:0] a_q;
    logic       a_tc, a_tc_r;

    ic_mod_counter #(.WIDTH(3), .MODULUS(8), .RESET_VALUE(5)) u_a (
        .cp(clk), .mr(a_mr), .pe_n(1'b1), .p(3'd0), .cep(a_en), .cet(a_en), .ud(1'b1),
        .q(a_q), .tc(a_tc), .tc_r(a_tc_r)
    );

    // WIDTH=8, MODULUS=200
    logic       b_pe_n, b_en;
    logic [7:0] b_p;
    logic [7:0] b_q;
    logic       b_tc, b_tc_r;

    ic_mod_counter #(.WIDTH(8), .MODULUS(200), .RESET_VALUE(0)) u_b (
        .cp(clk), .mr(1'b0), .pe_n(b_pe_n), .p(b_p), .cep(b_en), .cet(b_en), .ud(1'b1),
        .q(b_q), .tc(b_tc), .tc_r(b_tc_r)
    );

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        mr = 1'b1; pe_n = 1'b1; p = 4'd0; cep = 1'b1; cet = 1'b1; ud = 1'b1;
        tick();
        tick();
        checks++;
        if (q !== 4'd0) $display("FAIL reset_q: got %0d want 0", q); else passes++;
        checks++;
        if (tc_r !== 1'b0) $display("FAIL reset_tc_r: got %b want 0", tc_r); else passes++;
        checks++;
        if (tc !== 1'b0) $display("FAIL reset_tc: got %b want 0", tc); else passes++;
    endtask

    task automatic test_count_up();
        logic [3:0] exp;
        mr = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            exp = 4'(i % 10);
            checks++;
            if (q !== exp) $display("FAIL up_q[%0d]: got %0d want %0d", i, q, exp);
            else passes++;
            checks++;
            if (tc !== (exp == 4'd9)) $display("FAIL up_tc[%0d]: got %b", i, tc);
            else passes++;
            checks++;
            if (tc_r !== (i == 10)) $display("FAIL up_tc_r[%0d]: got %b", i, tc_r);
            else passes++;
        end
    endtask

    task automatic test_load();
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'd5; exp_seq[1] = 4'd6; exp_seq[2] = 4'd7;
        pe_n = 1'b0; p = 4'd3;
        tick();
        checks++;
        if (q !== 4'd3) $display("FAIL load3_q: got %0d want 3", q); else passes++;
        // Load must win over an active count enable.
        p = 4'd5;
        tick();
        pe_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            checks++;
            if (q !== exp_seq[i]) $display("FAIL load_seq[%0d]: got %0d want %0d", i, q, exp_seq[i]);
            else passes++;
        end
        pe_n = 1'b0; p = 4'd12;
        tick();
        pe_n = 1'b1;
        checks++;
        if (q !== 4'd12) $display("FAIL load_oor_q: got %0d want 12", q); else passes++;
        checks++;
        if (tc !== 1'b0) $display("FAIL load_oor_tc: got %b want 0", tc); else passes++;
        tick();
        checks++;
        if (q !== 4'd0) $display("FAIL oor_recover_q: got %0d want 0", q); else passes++;
        checks++;
        if (tc_r !== 1'b0) $display("FAIL oor_recover_tc_r: got %b want 0", tc_r); else passes++;
    endtask

    task automatic test_down();
        logic [3:0] exp_q [4];
        logic       exp_r [4];
        exp_q[0] = 4'd1; exp_q[1] = 4'd0; exp_q[2] = 4'd9; exp_q[3] = 4'd8;
        exp_r[0] = 1'b0; exp_r[1] = 1'b0; exp_r[2] = 1'b1; exp_r[3] = 1'b0;
        pe_n = 1'b0; p = 4'd2;
        tick();
        pe_n = 1'b1; ud = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (q !== exp_q[i]) $display("FAIL down_q[%0d]: got %0d want %0d", i, q, exp_q[i]);
            else passes++;
            checks++;
            if (tc !== (exp_q[i] == 4'd0)) $display("FAIL down_tc[%0d]: got %b", i, tc);
            else passes++;
            checks++;
            if (tc_r !== exp_r[i]) $display("FAIL down_tc_r[%0d]: got %b want %b", i, tc_r, exp_r[i]);
            else passes++;
        end
        ud = 1'b1;
        #1;
        checks++;
        if (tc !== 1'b0) $display("FAIL ud_flip_tc_at8: got %b want 0", tc); else passes++;
        tick();
        checks++;
        if (q !== 4'd9) $display("FAIL ud_flip_q: got %0d want 9", q); else passes++;
        checks++;
        if (tc !== 1'b1) $display("FAIL ud_flip_tc_at9: got %b want 1", tc); else passes++;
        // tc follows ud combinationally without an edge.
        cep = 1'b0; ud = 1'b0;
        #1;
        checks++;
        if (tc !== 1'b0) $display("FAIL ud_comb_down_tc: got %b want 0", tc); else passes++;
        // Out-of-range down step lands on MODULUS-1 with no carry.
        pe_n = 1'b0; p = 4'd14;
        tick();
        pe_n = 1'b1; cep = 1'b1;
        tick();
        checks++;
        if (q !== 4'd9) $display("FAIL oor_down_q: got %0d want 9", q); else passes++;
        checks++;
        if (tc_r !== 1'b0) $display("FAIL oor_down_tc_r: got %b want 0", tc_r); else passes++;
        ud = 1'b1;
    endtask

    task automatic test_enables();
        cep = 1'b0; cet = 1'b1;
        tick();
        checks++;
        if (q !== 4'd9) $display("FAIL cep_hold_q: got %0d want 9", q); else passes++;
        checks++;
        if (tc !== 1'b1) $display("FAIL cep_hold_tc: got %b want 1", tc); else passes++;
        cet = 1'b0; cep = 1'b1;
        #1;
        checks++;
        if (tc !== 1'b0) $display("FAIL cet_gate_tc: got %b want 0", tc); else passes++;
        tick();
        checks++;
        if (q !== 4'd9) $display("FAIL cet_hold_q: got %0d want 9", q); else passes++;
        mr = 1'b1; pe_n = 1'b0; p = 4'd7; cet = 1'b1;
        tick();
        checks++;
        if (q !== 4'd0) $display("FAIL mr_beats_load_q: got %0d want 0", q); else passes++;
        mr = 1'b0; pe_n = 1'b1;
        tick();
        checks++;
        if (q !== 4'd1) $display("FAIL resume_q: got %0d want 1", q); else passes++;
    endtask

    task automatic test_cascade();
        logic [3:0] exp_lo, exp_hi;
        c_mr = 1'b1; c_cep = 1'b1;
        tick();
        c_mr = 1'b0;
        checks++;
        if ({hi_q, lo_q} !== 8'h00) $display("FAIL casc_reset: got %h want 00", {hi_q, lo_q});
        else passes++;
        for (int i = 1; i <= 100; i++) begin
            tick();
            exp_lo = 4'((i % 100) % 10);
            exp_hi = 4'((i % 100) / 10);
            checks++;
            if (lo_q !== exp_lo || hi_q !== exp_hi)
                $display("FAIL casc_q[%0d]: got %0d%0d want %0d%0d", i, hi_q, lo_q, exp_hi, exp_lo);
            else passes++;
            checks++;
            if (hi_tc !== (i == 99)) $display("FAIL casc_hi_tc[%0d]: got %b", i, hi_tc);
            else passes++;
        end
        checks++;
        if (hi_tc_r !== 1'b1 || lo_tc_r !== 1'b1)
            $display("FAIL casc_tc_r: got hi=%b lo=%b want 1 1", hi_tc_r, lo_tc_r);
        else passes++;
        c_cep = 1'b0;
    endtask

    task automatic test_params();
        logic [2:0] a_exp [4];
        a_exp[0] = 3'd6; a_exp[1] = 3'd7; a_exp[2] = 3'd0; a_exp[3] = 3'd1;
        a_mr = 1'b1; a_en = 1'b1;
        tick();
        a_mr = 1'b0;
        checks++;
        if (a_q !== 3'd5) $display("FAIL w3_reset_q: got %0d want 5", a_q); else passes++;
        checks++;
        if (a_tc_r !== 1'b0) $display("FAIL w3_reset_tc_r: got %b want 0", a_tc_r); else passes++;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (a_q !== a_exp[i]) $display("FAIL w3_q[%0d]: got %0d want %0d", i, a_q, a_exp[i]);
            else passes++;
            checks++;
            if (a_tc !== (a_exp[i] == 3'd7)) $display("FAIL w3_tc[%0d]: got %b", i, a_tc);
            else passes++;
            checks++;
            if (a_tc_r !== (i == 2)) $display("FAIL w3_tc_r[%0d]: got %b", i, a_tc_r);
            else passes++;
        end
        b_pe_n = 1'b0; b_p = 8'd198; b_en = 1'b1;
        tick();
        b_pe_n = 1'b1;
        checks++;
        if (b_q !== 8'd198) $display("FAIL w8_load_q: got %0d want 198", b_q); else passes++;
        tick();
        checks++;
        if (b_q !== 8'd199 || b_tc !== 1'b1)
            $display("FAIL w8_top: got q=%0d tc=%b want 199 1", b_q, b_tc);
        else passes++;
        tick();
        checks++;
        if (b_q !== 8'd0 || b_tc_r !== 1'b1 || b_tc !== 1'b0)
            $display("FAIL w8_wrap: got q=%0d tc_r=%b tc=%b want 0 1 0", b_q, b_tc_r, b_tc);
        else passes++;
    endtask

    initial begin
        mr = 1'b1; pe_n = 1'b1; p = 4'd0; cep = 1'b0; cet = 1'b0; ud = 1'b1;
        c_mr = 1'b1; c_cep = 1'b0;
        a_mr = 1'b1; a_en = 1'b0;
        b_pe_n = 1'b1; b_p = 8'd0; b_en = 1'b0;
        test_reset();
        test_count_up();
        test_load();
        test_down();
        test_enables();
        test_cascade();
        test_params();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
